// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial shared-adder arbiter.
package add_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    localparam int unsigned REQ0 = 0;
    localparam int unsigned REQ1 = 1;
    localparam int unsigned IDXW = 3;

endpackage

// File: rtl/add8_cla.sv
// 8-bit carry-lookahead adder, purely combinational.
module add8_cla
    import add_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [7:0] w_c;
    logic       w_carry;

    assign w_g = a & b;
    assign w_p = a | b;

    // Carry chain evaluated through a local variable to keep the vector acyclic.
    always_comb begin
        w_c     = '0;
        w_carry = cin;
        for (int i = 0; i < 8; i++) begin
            w_c[i]  = w_carry;
            w_carry = w_g[i] | (w_p[i] & w_carry);
        end
    end

    assign sum  = a ^ b ^ w_c;
    assign cout = w_carry;

endmodule

// File: rtl/add_seq_arb.sv
// Two-requester round-robin arbiter sharing one 8-bit adder for
// NBYTES-wide additions, processed one byte per cycle, LSB first.
module add_seq_arb
    import add_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_i,
    input  logic [8*NBYTES-1:0]   a0_i,
    input  logic [8*NBYTES-1:0]   b0_i,
    input  logic                  cin0_i,
    input  logic [8*NBYTES-1:0]   a1_i,
    input  logic [8*NBYTES-1:0]   b1_i,
    input  logic                  cin1_i,
    output logic [1:0]            ack_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [8*NBYTES-1:0]   sum_o,
    output logic                  cout_o,
    output logic                  ovf_o,
    output logic                  owner_o
);

    localparam int unsigned W = 8 * NBYTES;

    state_t          r_state;
    logic            r_rr_ptr;
    logic [W-1:0]    r_a_sh;
    logic [W-1:0]    r_b_sh;
    logic [W-1:0]    r_sum_sh;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic            r_owner_int;
    logic            r_a_msb;
    logic            r_b_msb;

    logic [1:0]      r_ack;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;
    logic            r_owner;

    logic            w_winner;
    logic [W-1:0]    w_win_a;
    logic [W-1:0]    w_win_b;
    logic            w_win_cin;
    logic [7:0]      w_sum8;
    logic            w_cout8;
    logic [W+7:0]    w_cat;
    logic [W-1:0]    w_sum_next;
    logic            w_last;

    // Sole requester wins outright; a tie goes to the round-robin pointer.
    always_comb begin
        w_winner = r_rr_ptr;
        if (req_i == 2'b01) begin
            w_winner = 1'(REQ0);
        end else if (req_i == 2'b10) begin
            w_winner = 1'(REQ1);
        end
    end

    assign w_win_a   = w_winner ? a1_i   : a0_i;
    assign w_win_b   = w_winner ? b1_i   : b0_i;
    assign w_win_cin = w_winner ? cin1_i : cin0_i;

    add8_cla u_add8 (
        .a    (r_a_sh[7:0]),
        .b    (r_b_sh[7:0]),
        .cin  (r_carry),
        .sum  (w_sum8),
        .cout (w_cout8)
    );

    // New byte enters at the MSB end; after NBYTES steps the word is aligned.
    assign w_cat      = {w_sum8, r_sum_sh};
    assign w_sum_next = W'(w_cat >> 8);
    assign w_last     = (r_idx == IDXW'(NBYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_owner_int <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_owner     <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req_i) begin
                        r_a_sh          <= w_win_a;
                        r_b_sh          <= w_win_b;
                        r_a_msb         <= w_win_a[W-1];
                        r_b_msb         <= w_win_b[W-1];
                        r_carry         <= w_win_cin;
                        r_sum_sh        <= '0;
                        r_idx           <= '0;
                        r_ack[w_winner] <= 1'b1;
                        r_owner_int     <= w_winner;
                        r_rr_ptr        <= ~w_winner;
                        r_busy          <= 1'b1;
                        r_state         <= ADD;
                    end
                end
                ADD: begin
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_cout8;
                    r_a_sh   <= r_a_sh >> 8;
                    r_b_sh   <= r_b_sh >> 8;
                    r_idx    <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_sum   <= w_sum_next;
                        r_cout  <= w_cout8;
                        r_owner <= r_owner_int;
                        r_ovf   <= (r_a_msb == r_b_msb) && (w_sum8[7] != r_a_msb);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack_o   = r_ack;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign sum_o   = r_sum;
    assign cout_o  = r_cout;
    assign ovf_o   = r_ovf;
    assign owner_o = r_owner;

endmodule

// File: tb/tb_add_seq_arb.sv
// Self-checking bench for add_seq_arb: directed table, random ops against a
// wide-arithmetic reference, mid-operation reset and back-to-back arbitration.
module tb_add_seq_arb;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_i;
    logic [W-1:0] a0_i, b0_i, a1_i, b1_i;
    logic         cin0_i, cin1_i;
    logic [1:0]   ack_o;
    logic         busy_o, done_o, cout_o, ovf_o, owner_o;
    logic [W-1:0] sum_o;

    int checks   = 0;
    int failures = 0;

    add_seq_arb #(.NBYTES(NBYTES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .a0_i    (a0_i),
        .b0_i    (b0_i),
        .cin0_i  (cin0_i),
        .a1_i    (a1_i),
        .b1_i    (b1_i),
        .cin1_i  (cin1_i),
        .ack_o   (ack_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o),
        .owner_o (owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         who;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: full-width integer add; cout is bit W, ovf from operand/result signs.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin);
        logic [W:0] s;
        logic       ovf;
        s   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {ovf, s};
    endfunction

    task automatic scramble();
        a0_i = $urandom; b0_i = $urandom; cin0_i = 1'($urandom);
        a1_i = $urandom; b1_i = $urandom; cin1_i = 1'($urandom);
    endtask

    // Called at a negedge with the DUT idle; runs one single-requester op.
    task automatic do_op(input string tag, input logic who, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        if (who) begin
            a1_i = a; b1_i = b; cin1_i = cin; req_i = 2'b10;
        end else begin
            a0_i = a; b0_i = b; cin0_i = cin; req_i = 2'b01;
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ack"}, 64'(ack_o), who ? 64'd2 : 64'd1);
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        req_i = 2'b00;
        scramble();
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk);
            n++;
            scramble();
        end
        chk({tag, "_latency"}, 64'(n), 64'(NBYTES));
        if (done_o) begin
            chk({tag, "_sum"},   64'(sum_o),   64'(es));
            chk({tag, "_cout"},  64'(cout_o),  64'(ec));
            chk({tag, "_ovf"},   64'(ovf_o),   64'(eo));
            chk({tag, "_owner"}, 64'(owner_o), 64'(who));
            chk({tag, "_busy_end"}, 64'(busy_o), 64'd0);
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
        chk({tag, "_sum_held"}, 64'(sum_o), 64'(es));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   64'(ack_o),   64'd0);
        chk({tag, "_busy"},  64'(busy_o),  64'd0);
        chk({tag, "_done"},  64'(done_o),  64'd0);
        chk({tag, "_sum"},   64'(sum_o),   64'd0);
        chk({tag, "_cout"},  64'(cout_o),  64'd0);
        chk({tag, "_ovf"},   64'(ovf_o),   64'd0);
        chk({tag, "_owner"}, 64'(owner_o), 64'd0);
    endtask

    initial begin
        logic [W+1:0] r;
        logic [W-1:0] ra, rb;
        logic         rw, rc;
        int           dones, last_done;
        logic         exp_owner;

        vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};

        rst_n = 1'b0;
        req_i = 2'b00;
        a0_i = '0; b0_i = '0; cin0_i = 1'b0;
        a1_i = '0; b1_i = '0; cin1_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        for (int i = 0; i < 30; i++) begin
            rw = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            r = ref_add(ra, rb, rc);
            do_op($sformatf("rand%0d", i), rw, ra, rb, rc, r[W-1:0], r[W], r[W+1]);
        end

        // Reset while the third byte is being added.
        a0_i = 32'h11111111; b0_i = 32'h22222222; cin0_i = 1'b0; req_i = 2'b01;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_ack", 64'(ack_o), 64'd1);
        req_i = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        chk("rstmid_no_done", 64'(dones), 64'd0);
        do_op("after_rst", 1'b1, 32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 1'b0);

        // Both requesters held from reset: grants alternate, one op per 5 cycles.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a0_i = 32'h01020304; b0_i = 32'h10203040; cin0_i = 1'b1;
        a1_i = 32'hF0000000; b1_i = 32'h20000001; cin1_i = 1'b0;
        req_i = 2'b11;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_first_ack", 64'(ack_o), 64'd1);
        dones = 0;
        last_done = 0;
        exp_owner = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (cyc > 0) @(negedge clk);
            chk($sformatf("b2b_busy_gap_c%0d", cyc), 64'(!busy_o), 64'(done_o));
            if (done_o) begin
                r = exp_owner ? ref_add(a1_i, b1_i, cin1_i) : ref_add(a0_i, b0_i, cin0_i);
                chk($sformatf("b2b_owner%0d", dones), 64'(owner_o), 64'(exp_owner));
                chk($sformatf("b2b_sum%0d", dones), 64'(sum_o), 64'(r[W-1:0]));
                chk($sformatf("b2b_cout%0d", dones), 64'(cout_o), 64'(r[W]));
                if (dones > 0)
                    chk($sformatf("b2b_period%0d", dones), 64'(cyc - last_done), 64'(NBYTES + 1));
                last_done = cyc;
                dones++;
                exp_owner = ~exp_owner;
            end
        end
        chk("b2b_done_count", 64'(dones), 64'd5);
        req_i = 2'b00;
        repeat (2) @(negedge clk);
        chk("b2b_idle_busy", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
